// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling of a 2-flop synchronised rx line,
// configurable data width, parity and stop bits, with a valid/ready output holding register.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] BIT_RELOAD  = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] HALF_RELOAD = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic PARITY_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta, rx_s;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_acc_q, par_acc_d;
    logic                  par_bad_q, par_bad_d;
    logic                  tick_done;
    logic                  deliver;
    logic                  stop_fail;

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset
    // sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick_done = (tick_q == '0);
    assign busy      = (state_q != IDLE);

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        par_bad_d = par_bad_q;
        deliver   = 1'b0;
        stop_fail = 1'b0;

        if (state_q != IDLE && state_q != WAIT_IDLE && !tick_done) begin
            tick_d = tick_q - TICK_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    tick_d    = HALF_RELOAD;
                    bit_cnt_d = '0;
                    par_acc_d = 1'b0;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (tick_done) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        tick_d  = BIT_RELOAD;
                    end
                end
            end
            DATA: begin
                if (tick_done) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    par_acc_d = par_acc_q ^ rx_s;
                    tick_d    = BIT_RELOAD;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick_done) begin
                    par_bad_d = (rx_s != (par_acc_q ^ PARITY_SENSE));
                    tick_d    = BIT_RELOAD;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick_done) begin
                    tick_d = BIT_RELOAD;
                    if (!rx_s) begin
                        stop_fail = 1'b1;
                        state_d   = WAIT_IDLE;
                    end else if (bit_cnt_q == LAST_STOP) begin
                        // Returning to IDLE mid-stop-bit lets a back-to-back start edge be seen.
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_acc_q <= par_acc_d;
            par_bad_q <= par_bad_d;
        end
    end

    // Holding register: a new word may replace the old one only if it was just accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_fail;
            overrun   <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (deliver) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift_q;
                    parity_err <= par_bad_q;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations (8E1, 8N2, 7O1) driven
// from frames built by a behavioural frame model, with pulse/valid monitors.
module tb_uart_rx_param;

    localparam int CPB = 16;
    localparam int NOMINAL_LAT_8E1 = 171;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] rx_v;
    logic [2:0] ready_v;
    logic [2:0] dv, pe, fe, ov, bsy;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int fe_cnt[3], ov_cnt[3], rise_cnt[3], rise_cyc[3], busy_cnt[3];
    logic [2:0] dv_prev;

    always #5 clk = ~clk;

    uart_rx_param dut (
        .clk(clk), .rst(rst_v[0]), .rx(rx_v[0]), .data_out(dout0), .data_valid(dv[0]),
        .data_ready(ready_v[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bsy[0])
    );

    uart_rx_param #(.PARITY_EN(0), .STOP_BITS(2)) dut_8n2 (
        .clk(clk), .rst(rst_v[1]), .rx(rx_v[1]), .data_out(dout1), .data_valid(dv[1]),
        .data_ready(ready_v[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bsy[1])
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY_ODD(1)) dut_7o1 (
        .clk(clk), .rst(rst_v[2]), .rx(rx_v[2]), .data_out(dout2), .data_valid(dv[2]),
        .data_ready(ready_v[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bsy[2])
    );

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 3; i++) begin
            fe_cnt[i] = 0; ov_cnt[i] = 0; rise_cnt[i] = 0; rise_cyc[i] = -1; busy_cnt[i] = 0;
        end
        dv_prev = '0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fe[i]) fe_cnt[i] <= fe_cnt[i] + 1;
            if (ov[i]) ov_cnt[i] <= ov_cnt[i] + 1;
            if (bsy[i]) busy_cnt[i] <= busy_cnt[i] + 1;
            if (dv[i] && !dv_prev[i]) begin
                rise_cnt[i] <= rise_cnt[i] + 1;
                rise_cyc[i] <= cyc;
            end
        end
        dv_prev <= dv;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame model: start bit, data LSB first, optional parity, stop bits.
    function automatic void build_frame(input int dbits, input bit pen, input bit podd,
                                        input int sbits, input int word, input bit flip_par,
                                        input bit low_last_stop, output logic [15:0] f,
                                        output int n);
        int  ones;
        logic pbit;
        f = '1;
        n = 0;
        f[n] = 1'b0; n++;
        ones = 0;
        for (int i = 0; i < dbits; i++) begin
            f[n] = word[i]; n++;
            if (word[i]) ones++;
        end
        if (pen) begin
            pbit = ((ones % 2) == 1) ^ podd;
            f[n] = pbit ^ flip_par; n++;
        end
        for (int i = 0; i < sbits; i++) begin
            f[n] = (low_last_stop && i == sbits - 1) ? 1'b0 : 1'b1; n++;
        end
    endfunction

    task automatic drive_bit(input int which, input logic b, input int cycles);
        rx_v[which] = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) drive_bit(which, f[i], CPB);
    endtask

    task automatic accept(input int which);
        ready_v[which] = 1'b1;
        @(negedge clk);
        ready_v[which] = 1'b0;
    endtask

    initial begin
        logic [15:0] f;
        int n, t0, lat, word;
        int fe_s, ov_s, rise_s, busy_s;
        bit flip;

        rst_v = '1; rx_v = '1; ready_v = '0;
        repeat (4) @(negedge clk);
        rst_v = '0;
        @(negedge clk);

        check("rst_data_out", dout0, 0);
        check("rst_valid", dv, 0);
        check("rst_parity_err", pe, 0);
        check("rst_frame_err", fe, 0);
        check("rst_overrun", ov, 0);
        check("rst_busy", bsy, 0);

        // 8E1 0xA5 with correct parity, plus latency
        rise_s = rise_cnt[0];
        build_frame(8, 1, 0, 1, 'hA5, 0, 0, f, n);
        t0 = cyc;
        send_frame(0, f, n);
        repeat (8) @(negedge clk);
        lat = rise_cyc[0] - t0;
        check("a5_delivered", rise_cnt[0] - rise_s, 1);
        check("a5_data", dout0, 'hA5);
        check("a5_parity_err", pe[0], 0);
        check("a5_latency_within_1", (lat >= NOMINAL_LAT_8E1 - 1 && lat <= NOMINAL_LAT_8E1 + 1), 1);
        accept(0);
        check("a5_accepted", dv[0], 0);

        // 8E1 0x3C with a wrong parity bit
        build_frame(8, 1, 0, 1, 'h3C, 1, 0, f, n);
        send_frame(0, f, n);
        repeat (8) @(negedge clk);
        check("3c_data", dout0, 'h3C);
        check("3c_parity_err", pe[0], 1);
        check("3c_valid", dv[0], 1);
        accept(0);

        // Randomised 8E1 words with random parity corruption
        for (int k = 0; k < 8; k++) begin
            word = $urandom_range(0, 255);
            flip = 1'($urandom_range(0, 1));
            build_frame(8, 1, 0, 1, word, flip, 0, f, n);
            send_frame(0, f, n);
            repeat (4) @(negedge clk);
            check("rand_data", dout0, word);
            check("rand_parity_err", pe[0], flip);
            check("rand_valid", dv[0], 1);
            accept(0);
        end

        // 8N2 0x55 with the 2nd stop bit low, then a long break
        fe_s = fe_cnt[1]; rise_s = rise_cnt[1];
        build_frame(8, 0, 0, 2, 'h55, 0, 1, f, n);
        send_frame(0 + 1, f, n);
        drive_bit(1, 1'b0, 40 * CPB);
        drive_bit(1, 1'b1, 3 * CPB);
        check("break_one_frame_err", fe_cnt[1] - fe_s, 1);
        check("break_no_delivery", rise_cnt[1] - rise_s, 0);
        check("break_valid_low", dv[1], 0);
        build_frame(8, 0, 0, 2, 'h81, 0, 0, f, n);
        send_frame(1, f, n);
        repeat (4) @(negedge clk);
        check("8n2_81_data", dout1, 'h81);
        check("8n2_81_valid", dv[1], 1);
        check("8n2_parity_err", pe[1], 0);
        accept(1);

        // Start-bit glitch of 6 cycles
        fe_s = fe_cnt[0]; ov_s = ov_cnt[0]; rise_s = rise_cnt[0]; busy_s = busy_cnt[0];
        drive_bit(0, 1'b0, 6);
        drive_bit(0, 1'b1, 2 * CPB);
        check("glitch_busy_seen", (busy_cnt[0] - busy_s) > 0, 1);
        check("glitch_busy_released", bsy[0], 0);
        check("glitch_no_delivery", rise_cnt[0] - rise_s, 0);
        check("glitch_no_frame_err", fe_cnt[0] - fe_s, 0);
        check("glitch_no_overrun", ov_cnt[0] - ov_s, 0);

        // Back-to-back 0x11 / 0x22 with nobody accepting
        ov_s = ov_cnt[0];
        build_frame(8, 1, 0, 1, 'h11, 0, 0, f, n);
        send_frame(0, f, n);
        build_frame(8, 1, 0, 1, 'h22, 0, 0, f, n);
        send_frame(0, f, n);
        repeat (4) @(negedge clk);
        check("b2b_keeps_first", dout0, 'h11);
        check("b2b_one_overrun", ov_cnt[0] - ov_s, 1);
        check("b2b_valid", dv[0], 1);
        accept(0);

        // Same again, accepting exactly on the second delivery cycle
        build_frame(8, 1, 0, 1, 'h11, 0, 0, f, n);
        send_frame(0, f, n);
        ov_s = ov_cnt[0];
        build_frame(8, 1, 0, 1, 'h22, 0, 0, f, n);
        fork
            send_frame(0, f, n);
            begin
                repeat (NOMINAL_LAT_8E1 - 1) @(negedge clk);
                accept(0);
            end
        join
        repeat (4) @(negedge clk);
        check("accept_same_cycle_data", dout0, 'h22);
        check("accept_same_cycle_no_overrun", ov_cnt[0] - ov_s, 0);
        check("accept_same_cycle_valid", dv[0], 1);
        accept(0);

        // 7O1: leave a word pending, abort a frame with rst, then receive 0x05
        word = $urandom_range(1, 127);
        build_frame(7, 1, 1, 1, word, 1, 0, f, n);
        send_frame(2, f, n);
        repeat (4) @(negedge clk);
        check("7o1_pending_data", dout2, word);
        check("7o1_pending_parity_err", pe[2], 1);
        drive_bit(2, 1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bit(2, 1'b1, CPB);
        check("7o1_busy_mid_data", bsy[2], 1);
        rst_v[2] = 1'b1;
        repeat (2) @(negedge clk);
        rst_v[2] = 1'b0;
        @(negedge clk);
        check("7o1_rst_data_out", dout2, 0);
        check("7o1_rst_valid", dv[2], 0);
        check("7o1_rst_parity_err", pe[2], 0);
        check("7o1_rst_frame_err", fe[2], 0);
        check("7o1_rst_overrun", ov[2], 0);
        check("7o1_rst_busy", bsy[2], 0);
        fe_s = fe_cnt[2];
        repeat (2 * CPB) @(negedge clk);
        build_frame(7, 1, 1, 1, 'h05, 0, 0, f, n);
        send_frame(2, f, n);
        repeat (4) @(negedge clk);
        check("7o1_05_data", dout2, 'h05);
        check("7o1_05_parity_err", pe[2], 0);
        check("7o1_05_valid", dv[2], 1);
        check("7o1_no_frame_err", fe_cnt[2] - fe_s, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
